// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-wide external memory bus shared by instruction fetch and
// the load/store buffer, with round-robin arbitration.
//
// Ports:
//   clk, rst (async, active-low), rdy (global stall), clear (flush)
//   inst_valid/inst_addr        -> inst_ready/inst_res   (32-bit fetch)
//   data_valid/data_wr/data_type/data_addr/data_value
//                               -> data_ready/data_res   (1/2/4-byte ld/st)
//   mem_din, mem_dout, mem_a, mem_wr : external byte bus
//   io_buffer_full : UART tx buffer full, stalls I/O writes
module mem_ctrl #(
   parameter int         ADDR_WIDTH = 32,
   parameter logic [1:0] IO_SEL     = 2'b11
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  rdy,
   input  logic                  clear,
   input  logic                  inst_valid,
   input  logic [ADDR_WIDTH-1:0] inst_addr,
   output logic                  inst_ready,
   output logic [31:0]           inst_res,
   input  logic                  data_valid,
   input  logic                  data_wr,
   input  logic [2:0]            data_type,
   input  logic [ADDR_WIDTH-1:0] data_addr,
   input  logic [31:0]           data_value,
   output logic                  data_ready,
   output logic [31:0]           data_res,
   input  logic [7:0]            mem_din,
   output logic [7:0]            mem_dout,
   output logic [ADDR_WIDTH-1:0] mem_a,
   output logic                  mem_wr,
   input  logic                  io_buffer_full
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RD   = 2'd1,
      S_WR   = 2'd2,
      S_DONE = 2'd3
   } state_e;

   state_e                  state_q, state_d;

   logic                    last_data_q;
   logic                    src_inst_q;
   logic                    wr_q;
   logic                    sext_q;
   logic [1:0]              size_q;
   logic [2:0]              nb_q;
   logic [ADDR_WIDTH-1:0]   addr_q;
   logic [31:0]             val_q;
   logic [31:0]             buf_q, buf_d;
   logic [2:0]              cnt_q;
   logic                    pend_q;
   logic                    stale_q;
   logic [31:0]             inst_res_q;
   logic [31:0]             data_res_q;

   logic                    gnt_inst, gnt_data, gnt_any;
   logic [2:0]              data_nb;
   logic                    pv;
   logic [2:0]              cap_idx;
   logic [2:0]              bus_idx;
   logic                    rd_issue;
   logic                    last_cap;
   logic                    wr_last;
   logic                    io_hold;
   logic [31:0]             ld_ext;

   // ---------------- arbitration ----------------
   always_comb begin
      gnt_inst = 1'b0;
      gnt_data = 1'b0;
      if (state_q == S_IDLE && rdy && !clear) begin
         if (inst_valid && data_valid) begin
            if (last_data_q) gnt_inst = 1'b1;
            else             gnt_data = 1'b1;
         end else if (inst_valid) begin
            gnt_inst = 1'b1;
         end else if (data_valid) begin
            gnt_data = 1'b1;
         end
      end
   end

   assign gnt_any = gnt_inst | gnt_data;

   always_comb begin
      unique case (data_type[1:0])
         2'd0:    data_nb = 3'd1;
         2'd1:    data_nb = 3'd2;
         default: data_nb = 3'd4;
      endcase
   end

   // ---------------- read pipeline bookkeeping ----------------
   // pend_q: a byte was issued last active cycle, so mem_din holds byte
   // cnt_q now. stale_q: a freeze intervened, so mem_din is not trusted
   // and byte cnt_q must be re-issued.
   assign pv       = pend_q & ~stale_q;
   assign cap_idx  = cnt_q + {2'b00, pv};
   assign rd_issue = cap_idx < nb_q;
   assign last_cap = pv && ((cnt_q + 3'd1) == nb_q);
   assign wr_last  = (cnt_q + 3'd1) == nb_q;
   assign io_hold  = (addr_q[17:16] == IO_SEL) && io_buffer_full;

   // While frozen the bus shows what it showed when the freeze began.
   assign bus_idx  = rdy ? cap_idx : (cnt_q + {2'b00, pend_q});

   always_comb begin
      buf_d = buf_q;
      buf_d[{cnt_q[1:0], 3'b000} +: 8] = mem_din;
   end

   always_comb begin
      unique case (size_q)
         2'd0:    ld_ext = {{24{sext_q & buf_d[7]}}, buf_d[7:0]};
         2'd1:    ld_ext = {{16{sext_q & buf_d[15]}}, buf_d[15:0]};
         default: ld_ext = buf_d;
      endcase
   end

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= S_IDLE;
      else      state_q <= state_d;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_d = state_q;
      if (rdy) begin
         unique case (state_q)
            S_IDLE: begin
               if (gnt_inst)      state_d = S_RD;
               else if (gnt_data) state_d = data_wr ? S_WR : S_RD;
            end
            S_RD: begin
               if (clear)         state_d = S_IDLE;
               else if (last_cap) state_d = S_DONE;
            end
            S_WR: begin
               if (!io_hold && wr_last) state_d = S_DONE;
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // ---------------- datapath registers ----------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         last_data_q <= 1'b0;
         src_inst_q  <= 1'b0;
         wr_q        <= 1'b0;
         sext_q      <= 1'b0;
         size_q      <= 2'd0;
         nb_q        <= 3'd0;
         addr_q      <= '0;
         val_q       <= 32'd0;
         buf_q       <= 32'd0;
         cnt_q       <= 3'd0;
         pend_q      <= 1'b0;
         stale_q     <= 1'b0;
         inst_res_q  <= 32'd0;
         data_res_q  <= 32'd0;
      end else if (rdy) begin
         if (gnt_any) begin
            last_data_q <= gnt_data;
            src_inst_q  <= gnt_inst;
            wr_q        <= gnt_data & data_wr;
            sext_q      <= gnt_data & data_type[2];
            size_q      <= gnt_inst ? 2'd2 : data_type[1:0];
            nb_q        <= gnt_inst ? 3'd4 : data_nb;
            addr_q      <= gnt_inst ? inst_addr : data_addr;
            val_q       <= data_value;
            buf_q       <= 32'd0;
            cnt_q       <= 3'd0;
            pend_q      <= 1'b0;
            stale_q     <= 1'b0;
         end else begin
            unique case (state_q)
               S_RD: begin
                  stale_q <= 1'b0;
                  pend_q  <= rd_issue;
                  if (pv) begin
                     buf_q <= buf_d;
                     cnt_q <= cnt_q + 3'd1;
                  end
                  if (last_cap && !clear) begin
                     if (src_inst_q) inst_res_q <= buf_d;
                     else            data_res_q <= ld_ext;
                  end
               end
               S_WR: begin
                  if (!io_hold) cnt_q <= cnt_q + 3'd1;
               end
               default: ;
            endcase
         end
      end else if (state_q == S_RD) begin
         stale_q <= 1'b1;
      end
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      mem_a      = '0;
      mem_dout   = 8'd0;
      mem_wr     = 1'b0;
      inst_ready = 1'b0;
      data_ready = 1'b0;
      unique case (state_q)
         S_RD: begin
            if (bus_idx < nb_q)
               mem_a = addr_q + {{(ADDR_WIDTH-3){1'b0}}, bus_idx};
         end
         S_WR: begin
            mem_a    = addr_q + {{(ADDR_WIDTH-3){1'b0}}, cnt_q};
            mem_dout = val_q[{cnt_q[1:0], 3'b000} +: 8];
            mem_wr   = rdy & ~io_hold;
         end
         S_DONE: begin
            // A committed store reports even across a flush.
            inst_ready = src_inst_q & ~clear;
            data_ready = ~src_inst_q & (wr_q | ~clear);
         end
         default: ;
      endcase
   end

   assign inst_res = inst_res_q;
   assign data_res = data_res_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed tests for mem_ctrl with a byte memory model.
// Cycle 0 of a request is the cycle its valid is first presented.
module tb_mem_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        rdy;
   logic        clear;
   logic        inst_valid;
   logic [31:0] inst_addr;
   logic        inst_ready;
   logic [31:0] inst_res;
   logic        data_valid;
   logic        data_wr;
   logic [2:0]  data_type;
   logic [31:0] data_addr;
   logic [31:0] data_value;
   logic        data_ready;
   logic [31:0] data_res;
   logic [7:0]  mem_din;
   logic [7:0]  mem_dout;
   logic [31:0] mem_a;
   logic        mem_wr;
   logic        io_buffer_full;

   int checks = 0;
   int errors = 0;

   logic [7:0] rom [0:1023];
   logic [7:0] ram [0:1023];
   bit         ram_v [0:1023];
   int         wr_cnt = 0;

   mem_ctrl #(.ADDR_WIDTH(32), .IO_SEL(2'b11)) dut (
      .clk            (clk),
      .rst            (rst),
      .rdy            (rdy),
      .clear          (clear),
      .inst_valid     (inst_valid),
      .inst_addr      (inst_addr),
      .inst_ready     (inst_ready),
      .inst_res       (inst_res),
      .data_valid     (data_valid),
      .data_wr        (data_wr),
      .data_type      (data_type),
      .data_addr      (data_addr),
      .data_value     (data_value),
      .data_ready     (data_ready),
      .data_res       (data_res),
      .mem_din        (mem_din),
      .mem_dout       (mem_dout),
      .mem_a          (mem_a),
      .mem_wr         (mem_wr),
      .io_buffer_full (io_buffer_full)
   );

   always #5 clk = ~clk;

   // Byte memory: read data appears the cycle after the address.
   always @(posedge clk) begin
      mem_din <= ram_v[mem_a[9:0]] ? ram[mem_a[9:0]] : rom[mem_a[9:0]];
      if (mem_wr) begin
         ram[mem_a[9:0]]   <= mem_dout;
         ram_v[mem_a[9:0]] <= 1'b1;
         wr_cnt            <= wr_cnt + 1;
      end
   end

   task automatic next_cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic data_req(input logic wr, input logic [2:0] ty,
                           input logic [31:0] a, input logic [31:0] v,
                           output int cyc, output logic [31:0] res);
      data_wr    = wr;
      data_type  = ty;
      data_addr  = a;
      data_value = v;
      data_valid = 1'b1;
      cyc = -1;
      res = 32'd0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (data_ready) begin
            cyc = c;
            res = data_res;
            break;
         end
         next_cyc();
      end
      next_cyc();
      data_valid = 1'b0;
   endtask

   task automatic test_reset();
      #2;
      checks++;
      if (mem_a !== 32'd0 || mem_wr !== 1'b0 || mem_dout !== 8'd0) begin
         errors++;
         $display("FAIL reset_bus: mem_a=%h mem_wr=%b mem_dout=%h, want 0/0/0",
                  mem_a, mem_wr, mem_dout);
      end
      checks++;
      if (inst_ready !== 1'b0 || data_ready !== 1'b0) begin
         errors++;
         $display("FAIL reset_ready: inst_ready=%b data_ready=%b, want 0/0",
                  inst_ready, data_ready);
      end
      checks++;
      if (inst_res !== 32'd0 || data_res !== 32'd0) begin
         errors++;
         $display("FAIL reset_res: inst_res=%h data_res=%h, want 0/0",
                  inst_res, data_res);
      end
      @(negedge clk);
      rst = 1'b1;
      next_cyc();
   endtask

   task automatic test_fetch();
      inst_addr  = 32'h100;
      inst_valid = 1'b1;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (c >= 1 && c <= 4) begin
            checks++;
            if (mem_a !== 32'h100 + c - 1 || mem_wr !== 1'b0) begin
               errors++;
               $display("FAIL fetch_addr c%0d: mem_a=%h mem_wr=%b, want %h/0",
                        c, mem_a, mem_wr, 32'h100 + c - 1);
            end
         end
         checks++;
         if (inst_ready !== (c == 6)) begin
            errors++;
            $display("FAIL fetch_ready c%0d: got %b, want %b",
                     c, inst_ready, (c == 6));
         end
         if (c == 6) begin
            checks++;
            if (inst_res !== 32'h00100513) begin
               errors++;
               $display("FAIL fetch_res: got %h, want 00100513", inst_res);
            end
         end
         next_cyc();
         if (c == 6) inst_valid = 1'b0;
      end
   endtask

   task automatic test_loads();
      int          cyc;
      logic [31:0] res;
      data_req(1'b0, 3'b100, 32'h20, 32'd0, cyc, res);
      checks++;
      if (res !== 32'hFFFFFF80 || cyc !== 3) begin
         errors++;
         $display("FAIL lb_signed: res=%h cyc=%0d, want FFFFFF80 cyc 3", res, cyc);
      end
      data_req(1'b0, 3'b000, 32'h20, 32'd0, cyc, res);
      checks++;
      if (res !== 32'h00000080 || cyc !== 3) begin
         errors++;
         $display("FAIL lb_unsigned: res=%h cyc=%0d, want 00000080 cyc 3", res, cyc);
      end
      data_req(1'b0, 3'b101, 32'h22, 32'd0, cyc, res);
      checks++;
      if (res !== 32'hFFFF8001 || cyc !== 4) begin
         errors++;
         $display("FAIL lh_signed: res=%h cyc=%0d, want FFFF8001 cyc 4", res, cyc);
      end
      data_req(1'b0, 3'b001, 32'h22, 32'd0, cyc, res);
      checks++;
      if (res !== 32'h00008001) begin
         errors++;
         $display("FAIL lh_unsigned: res=%h, want 00008001", res);
      end
      data_req(1'b0, 3'b110, 32'h100, 32'd0, cyc, res);
      checks++;
      if (res !== 32'h00100513 || cyc !== 6) begin
         errors++;
         $display("FAIL lw: res=%h cyc=%0d, want 00100513 cyc 6", res, cyc);
      end
   endtask

   task automatic test_arbitration();
      int          d1, d2, i1, nd;
      logic [31:0] ires, dres;
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      next_cyc();
      d1 = -1; d2 = -1; i1 = -1; nd = 0;
      ires = 32'd0; dres = 32'd0;
      inst_addr  = 32'h100;
      inst_valid = 1'b1;
      data_wr    = 1'b0;
      data_type  = 3'b000;
      data_addr  = 32'h20;
      data_value = 32'd0;
      data_valid = 1'b1;
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         if (data_ready) begin
            if (nd == 0) d1 = c;
            else         d2 = c;
            nd++;
            dres = data_res;
         end
         if (inst_ready) begin
            i1   = c;
            ires = inst_res;
         end
         next_cyc();
         if (nd >= 2) data_valid = 1'b0;
         if (i1 >= 0) inst_valid = 1'b0;
      end
      checks++;
      if (d1 !== 3) begin
         errors++;
         $display("FAIL arb_first_data: ready cycle %0d, want 3", d1);
      end
      checks++;
      if (i1 !== 10) begin
         errors++;
         $display("FAIL arb_then_inst: ready cycle %0d, want 10", i1);
      end
      checks++;
      if (d2 !== 14) begin
         errors++;
         $display("FAIL arb_alternate: second data ready %0d, want 14", d2);
      end
      checks++;
      if (ires !== 32'h00100513 || dres !== 32'h00000080) begin
         errors++;
         $display("FAIL arb_results: inst=%h data=%h, want 00100513/00000080",
                  ires, dres);
      end
   endtask

   task automatic test_io_stall();
      data_wr        = 1'b1;
      data_type      = 3'b000;
      data_addr      = 32'h30000;
      data_value     = 32'h41;
      io_buffer_full = 1'b1;
      data_valid     = 1'b1;
      for (int c = 0; c < 7; c++) begin
         @(negedge clk);
         if (c >= 1 && c <= 3) begin
            checks++;
            if (mem_wr !== 1'b0) begin
               errors++;
               $display("FAIL io_hold c%0d: mem_wr=%b, want 0", c, mem_wr);
            end
         end
         if (c == 4) begin
            checks++;
            if (mem_wr !== 1'b1 || mem_a !== 32'h30000 || mem_dout !== 8'h41) begin
               errors++;
               $display("FAIL io_write: wr=%b a=%h d=%h, want 1/00030000/41",
                        mem_wr, mem_a, mem_dout);
            end
         end
         checks++;
         if (data_ready !== (c == 5)) begin
            errors++;
            $display("FAIL io_ready c%0d: got %b, want %b", c, data_ready, (c == 5));
         end
         next_cyc();
         if (c == 3) io_buffer_full = 1'b0;
         if (c == 5) data_valid = 1'b0;
      end
   endtask

   task automatic test_word_store();
      logic [7:0]  eb [4];
      int          cyc;
      logic [31:0] res;
      eb[0] = 8'hEF; eb[1] = 8'hBE; eb[2] = 8'hAD; eb[3] = 8'hDE;
      data_wr    = 1'b1;
      data_type  = 3'b010;
      data_addr  = 32'h40;
      data_value = 32'hDEADBEEF;
      data_valid = 1'b1;
      for (int c = 0; c < 7; c++) begin
         @(negedge clk);
         if (c >= 1 && c <= 4) begin
            checks++;
            if (mem_wr !== 1'b1 || mem_a !== 32'h40 + c - 1 || mem_dout !== eb[c-1]) begin
               errors++;
               $display("FAIL sw_byte c%0d: wr=%b a=%h d=%h, want 1/%h/%h",
                        c, mem_wr, mem_a, mem_dout, 32'h40 + c - 1, eb[c-1]);
            end
         end
         checks++;
         if (data_ready !== (c == 5)) begin
            errors++;
            $display("FAIL sw_ready c%0d: got %b, want %b", c, data_ready, (c == 5));
         end
         next_cyc();
         if (c == 5) data_valid = 1'b0;
      end
      data_req(1'b0, 3'b010, 32'h40, 32'd0, cyc, res);
      checks++;
      if (res !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL sw_readback: got %h, want DEADBEEF", res);
      end
   endtask

   task automatic test_clear_fetch();
      bit seen = 1'b0;
      inst_addr  = 32'h100;
      inst_valid = 1'b1;
      for (int c = 0; c < 11; c++) begin
         @(negedge clk);
         if (inst_ready) seen = 1'b1;
         if (c == 4) begin
            checks++;
            if (mem_a !== 32'd0 || mem_wr !== 1'b0) begin
               errors++;
               $display("FAIL clr_idle: mem_a=%h mem_wr=%b, want 0/0", mem_a, mem_wr);
            end
         end
         next_cyc();
         if (c == 2) begin
            clear      = 1'b1;
            inst_valid = 1'b0;
         end
         if (c == 3) clear = 1'b0;
      end
      checks++;
      if (seen !== 1'b0) begin
         errors++;
         $display("FAIL clr_no_ready: inst_ready seen %b, want 0", seen);
      end
   endtask

   task automatic test_clear_store();
      int w0;
      w0 = wr_cnt;
      data_wr    = 1'b1;
      data_type  = 3'b010;
      data_addr  = 32'h80;
      data_value = 32'h11223344;
      data_valid = 1'b1;
      for (int c = 0; c < 7; c++) begin
         @(negedge clk);
         checks++;
         if (data_ready !== (c == 5)) begin
            errors++;
            $display("FAIL clr_st_ready c%0d: got %b, want %b", c, data_ready, (c == 5));
         end
         next_cyc();
         if (c == 1) clear = 1'b1;
         if (c == 2) clear = 1'b0;
         if (c == 5) data_valid = 1'b0;
      end
      checks++;
      if (wr_cnt - w0 !== 4) begin
         errors++;
         $display("FAIL clr_st_count: %0d writes, want 4", wr_cnt - w0);
      end
      checks++;
      if ({ram[10'h83], ram[10'h82], ram[10'h81], ram[10'h80]} !== 32'h11223344) begin
         errors++;
         $display("FAIL clr_st_data: got %h, want 11223344",
                  {ram[10'h83], ram[10'h82], ram[10'h81], ram[10'h80]});
      end
   endtask

   task automatic test_rdy_stall();
      int          rc = -1;
      logic [31:0] r = 32'd0;
      logic [31:0] a3 = 32'd0;
      bit          wr_seen = 1'b0;
      inst_addr  = 32'h100;
      inst_valid = 1'b1;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         if (mem_wr !== 1'b0) wr_seen = 1'b1;
         if (c == 3) a3 = mem_a;
         if (c == 4) begin
            checks++;
            if (mem_a !== a3) begin
               errors++;
               $display("FAIL rdy_frozen: mem_a %h after %h, want unchanged", mem_a, a3);
            end
         end
         if (inst_ready) begin
            rc = c;
            r  = inst_res;
         end
         next_cyc();
         if (c == 2) rdy = 1'b0;
         if (c == 4) rdy = 1'b1;
         if (rc >= 0) inst_valid = 1'b0;
      end
      checks++;
      if (rc !== 9 || r !== 32'h00100513) begin
         errors++;
         $display("FAIL rdy_fetch: cycle %0d res %h, want 9 / 00100513", rc, r);
      end
      checks++;
      if (wr_seen !== 1'b0) begin
         errors++;
         $display("FAIL rdy_no_write: mem_wr seen %b, want 0", wr_seen);
      end
   endtask

   task automatic test_reset_mid_store();
      int          cyc;
      logic [31:0] res;
      data_wr    = 1'b1;
      data_type  = 3'b010;
      data_addr  = 32'h80;
      data_value = 32'hCAFEF00D;
      data_valid = 1'b1;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         if (c == 1) begin
            checks++;
            if (mem_wr !== 1'b1) begin
               errors++;
               $display("FAIL rst_pre_write: mem_wr=%b, want 1", mem_wr);
            end
         end
         next_cyc();
      end
      rst = 1'b0;
      #1;
      checks++;
      if (mem_wr !== 1'b0 || mem_a !== 32'd0 || mem_dout !== 8'd0 ||
          data_ready !== 1'b0 || inst_ready !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid_bus: wr=%b a=%h d=%h rdys=%b%b, want all 0",
                  mem_wr, mem_a, mem_dout, inst_ready, data_ready);
      end
      checks++;
      if (data_res !== 32'd0 || inst_res !== 32'd0) begin
         errors++;
         $display("FAIL rst_mid_res: data=%h inst=%h, want 0/0", data_res, inst_res);
      end
      data_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      next_cyc();
      data_req(1'b0, 3'b000, 32'h20, 32'd0, cyc, res);
      checks++;
      if (res !== 32'h80 || cyc !== 3) begin
         errors++;
         $display("FAIL rst_recover: res=%h cyc=%0d, want 00000080 cyc 3", res, cyc);
      end
   endtask

   initial begin
      rst            = 1'b0;
      rdy            = 1'b1;
      clear          = 1'b0;
      inst_valid     = 1'b0;
      inst_addr      = 32'd0;
      data_valid     = 1'b0;
      data_wr        = 1'b0;
      data_type      = 3'd0;
      data_addr      = 32'd0;
      data_value     = 32'd0;
      io_buffer_full = 1'b0;
      for (int i = 0; i < 1024; i++) rom[i] = 8'h00;
      rom[10'h100] = 8'h13;
      rom[10'h101] = 8'h05;
      rom[10'h102] = 8'h10;
      rom[10'h103] = 8'h00;
      rom[10'h020] = 8'h80;
      rom[10'h022] = 8'h01;
      rom[10'h023] = 8'h80;

      test_reset();
      test_fetch();
      test_loads();
      test_arbitration();
      test_io_stall();
      test_word_store();
      test_clear_fetch();
      test_clear_store();
      test_rdy_stall();
      test_reset_mid_store();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
